uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 14 +
 rtl/uart_tx_arbiter_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and default constants for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int N_REQ_DEF       = 4;
    localparam int DATA_W_DEF      = 8;
    localparam int TIMEOUT_CYC_DEF = 255;
    localparam int STALL_CNT_W     = 16;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin pick: first set request strictly after ptr, wrapping around.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     any_req
);

    localparam int IDX_W = $clog2(N_REQ);

    // Scan from farthest to nearest so the closest requester after ptr wins
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[IDX_W'((int'(ptr) + k) % N_REQ)]) begin
                winner  = IDX_W'((int'(ptr) + k) % N_REQ);
                any_req = 1'b1;
            end else begin
                winner  = winner;
                any_req = any_req;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter in front of a shared UART transmitter.
// Optional stall timeout is enabled with the UART_ARB_TIMEOUT_EN macro.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      tx_valid,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_ready,
    output logic [$clog2(N_REQ)-1:0]  grant_idx,
    output logic                      busy,
    output logic                      timeout
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e       state_r;
    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] grant_r;
    logic             busy_r;
    logic             timeout_r;
    logic [IDX_W-1:0] win_s;
    logic             any_s;
    logic             xfer_s;
    logic             expire_s;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (ptr_r),
        .winner  (win_s),
        .any_req (any_s)
    );

    assign xfer_s = (state_r == LOCK) && req_valid[grant_r] && tx_ready;

    // Owner's handshake is passed straight through while the grant is held
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (state_r == LOCK) begin
            tx_valid           = req_valid[grant_r];
            req_ready[grant_r] = tx_ready;
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_r == IDX_W'(i)) begin
                    tx_data = req_data[i*DATA_W +: DATA_W];
                end else begin
                    tx_data = tx_data;
                end
            end
        end else begin
            tx_valid  = 1'b0;
            tx_data   = '0;
            req_ready = '0;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_r;
    logic                   stall_s;

    assign stall_s  = (state_r == LOCK) && !req_valid[grant_r];
    assign expire_s = stall_s && (stall_cnt_r == STALL_CNT_W'(TIMEOUT_CYC - 1));

    // Stall counter: owner-idle LOCK cycles, cleared by any transfer or release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= '0;
        end else if ((state_r != LOCK) || xfer_s || expire_s) begin
            stall_cnt_r <= '0;
        end else if (stall_s) begin
            stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end
`else
    assign expire_s = 1'b0;
`endif

    // Grant FSM: arbitrate in IDLE, hold the owner until last beat or timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            ptr_r     <= IDX_W'(N_REQ - 1);
            grant_r   <= '0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        grant_r <= win_s;
                        busy_r  <= 1'b1;
                        state_r <= LOCK;
                    end
                end
                LOCK: begin
                    if (xfer_s && req_last[grant_r]) begin
                        ptr_r   <= grant_r;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (expire_s) begin
                        ptr_r     <= grant_r;
                        busy_r    <= 1'b0;
                        timeout_r <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign grant_idx = grant_r;
    assign busy      = busy_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner cases,
// and randomized traffic against a packet-level reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 5;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            tx_valid;
    logic [DW-1:0]   tx_data;
    logic            tx_ready;
    logic [1:0]      grant_idx;
    logic            busy;
    logic            timeout;

    int checks = 0;
    int errors = 0;

    // reference model: owner (-1 when no packet is in progress), pointer, etc.
    int m_owner;
    int m_ptr;
    int m_grant;
    int m_stall;
    int m_timeout;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] last;
        logic         txr;
        logic         busy;
        logic [1:0]   grant;
        logic         txv;
        logic [N-1:0] ready;
        logic [DW-1:0] data;
    } vec_t;

    vec_t tbl [10];

    uart_tx_arbiter #(
        .N_REQ       (N),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] byte_of(input int i);
        logic [DW-1:0] b;
        b = '0;
        for (int j = 0; j < N; j++) begin
            if (j == i) b = req_data[j*DW +: DW];
        end
        return b;
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = N - 1;
        m_grant   = 0;
        m_stall   = 0;
        m_timeout = 0;
    endtask

    task automatic model_check();
        logic         exp_txv;
        logic [N-1:0] exp_rdy;
        exp_txv = 1'b0;
        exp_rdy = '0;
        if (m_owner >= 0) begin
            exp_txv = req_valid[m_owner];
            if (tx_ready) exp_rdy[m_owner] = 1'b1;
            chk("model tx_data", 32'(tx_data), 32'(byte_of(m_owner)));
        end
        chk("model busy", 32'(busy), 32'(m_owner >= 0));
        chk("model grant_idx", 32'(grant_idx), 32'(m_grant));
        chk("model timeout", 32'(timeout), 32'(m_timeout));
        chk("model tx_valid", 32'(tx_valid), 32'(exp_txv));
        chk("model req_ready", 32'(req_ready), 32'(exp_rdy));
    endtask

    // advance the model by one clock edge using the inputs present at that edge
    task automatic model_update();
        m_timeout = 0;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (req_valid[c]) begin
                    m_owner = c;
                    m_grant = c;
                    m_stall = 0;
                    break;
                end
            end
        end else begin
            int o;
            o = m_owner;
            if (req_valid[o] && tx_ready) begin
                m_stall = 0;
                if (req_last[o]) begin
                    m_ptr   = o;
                    m_owner = -1;
                end
            end else if (!req_valid[o]) begin
`ifdef UART_ARB_TIMEOUT_EN
                m_stall = m_stall + 1;
                if (m_stall == TO) begin
                    m_timeout = 1;
                    m_ptr     = o;
                    m_owner   = -1;
                    m_stall   = 0;
                end
`endif
            end
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic adv();
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic tick();
        mid();
        adv();
    endtask

    task automatic set_req(input int i, input logic v, input logic [DW-1:0] d, input logic l);
        req_valid[i]        = v;
        req_data[i*DW +: DW] = d;
        req_last[i]         = l;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, " busy"}, 32'(busy), 32'h0);
        chk({nm, " grant_idx"}, 32'(grant_idx), 32'h0);
        chk({nm, " timeout"}, 32'(timeout), 32'h0);
        chk({nm, " tx_valid"}, 32'(tx_valid), 32'h0);
        chk({nm, " req_ready"}, 32'(req_ready), 32'h0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        #1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // round-robin over four always-valid single-byte requesters
        tbl[0] = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00};
        tbl[1] = '{4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h10};
        tbl[2] = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00};
        tbl[3] = '{4'hF, 4'hF, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 8'h11};
        tbl[4] = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000, 8'h00};
        tbl[5] = '{4'hF, 4'hF, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h12};
        tbl[6] = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0000, 8'h00};
        tbl[7] = '{4'hF, 4'hF, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000, 8'h13};
        tbl[8] = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0000, 8'h00};
        tbl[9] = '{4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h10};

        do_reset();
        req_data = 32'h13121110;
        for (int i = 0; i < 10; i++) begin
            req_valid = tbl[i].valid;
            req_last  = tbl[i].last;
            tx_ready  = tbl[i].txr;
            mid();
            chk("rr busy", 32'(busy), 32'(tbl[i].busy));
            chk("rr grant_idx", 32'(grant_idx), 32'(tbl[i].grant));
            chk("rr tx_valid", 32'(tx_valid), 32'(tbl[i].txv));
            chk("rr req_ready", 32'(req_ready), 32'(tbl[i].ready));
            if (tbl[i].busy) chk("rr tx_data", 32'(tx_data), 32'(tbl[i].data));
            adv();
        end

        // multi-byte packet from requester 2 while requester 1 keeps asking
        do_reset();
        tx_ready = 1'b1;
        set_req(1, 1'b1, 8'h55, 1'b1);
        set_req(2, 1'b1, 8'hA1, 1'b0);
        tick();
        mid();
        chk("pkt first owner", 32'(grant_idx), 32'd1);
        adv();
        tick();
        for (int b = 0; b < 3; b++) begin
            mid();
            chk("pkt grant_idx", 32'(grant_idx), 32'd2);
            chk("pkt tx_data", 32'(tx_data), 32'(8'hA1 + b));
            adv();
            set_req(2, (b < 2) ? 1'b1 : 1'b0, 8'(8'hA2 + b), (b == 1) ? 1'b1 : 1'b0);
        end
        tick();
        mid();
        chk("pkt next owner", 32'(grant_idx), 32'd1);
        chk("pkt next busy", 32'(busy), 32'd1);
        adv();

        // transmitter back-pressure for ten cycles
        do_reset();
        tx_ready = 1'b0;
        set_req(0, 1'b1, 8'h5A, 1'b1);
        tick();
        for (int s = 0; s < 10; s++) begin
            mid();
            chk("stall tx_valid", 32'(tx_valid), 32'd1);
            chk("stall tx_data", 32'(tx_data), 32'h5A);
            chk("stall req_ready", 32'(req_ready), 32'd0);
            adv();
        end
        tx_ready = 1'b1;
        mid();
        chk("stall release ready", 32'(req_ready), 32'b0001);
        adv();
        mid();
        chk("stall done busy", 32'(busy), 32'd0);
        adv();

        // reset in the middle of a four-byte packet
        do_reset();
        tx_ready = 1'b1;
        set_req(0, 1'b1, 8'hB0, 1'b0);
        set_req(1, 1'b1, 8'hC0, 1'b1);
        tick();
        mid();
        chk("abort byte1", 32'(tx_data), 32'hB0);
        adv();
        set_req(0, 1'b1, 8'hB1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        mid();
        chk("abort regrant idx", 32'(grant_idx), 32'd0);
        chk("abort regrant busy", 32'(busy), 32'd1);
        adv();

        // owner goes quiet mid-packet
        do_reset();
        tx_ready = 1'b1;
        set_req(1, 1'b1, 8'hC1, 1'b0);
        set_req(2, 1'b1, 8'hD2, 1'b1);
        tick();
        mid();
        chk("quiet owner", 32'(grant_idx), 32'd1);
        chk("quiet first byte", 32'(tx_valid), 32'd1);
        adv();
        set_req(1, 1'b0, 8'hC2, 1'b0);
        for (int s = 0; s < TO; s++) tick();
`ifdef UART_ARB_TIMEOUT_EN
        mid();
        chk("timeout pulse", 32'(timeout), 32'd1);
        chk("timeout busy", 32'(busy), 32'd0);
        adv();
        mid();
        chk("timeout next owner", 32'(grant_idx), 32'd2);
        chk("timeout pulse width", 32'(timeout), 32'd0);
        adv();
`else
        for (int s = 0; s < 15; s++) begin
            mid();
            chk("hold busy", 32'(busy), 32'd1);
            chk("hold grant_idx", 32'(grant_idx), 32'd1);
            chk("hold timeout", 32'(timeout), 32'd0);
            adv();
        end
`endif

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req_valid = N'($urandom);
            req_data  = $urandom;
            req_last  = N'($urandom & $urandom);
            tx_ready  = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
